icache_refill_controller: RTL
=============================

Name: icache_refill_controller

Overview:
Miss-handling sequencer for the fetch-stage instruction cache. It captures a read miss, issues one line-aligned read request to the memory side and counts response beats. Each beat is written into the data array; the tag/valid entry is written after the last beat. It then pulses completion so fetch can replay the access. Branch-redirect flushes cancel or drain an in-flight refill without corrupting the cache.

Parameters:
ADDR_WIDTH, 32, physical address width
WORD_WIDTH, 32, width of one response beat / instruction word
LINE_WORDS, 4, words per cache line (power of two, >=2)
INDEX_WIDTH, 6, cache set index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
missValid  in  1  fetch read missed this cycle (icRE && !hit)
missAddr  in  ADDR_WIDTH  address of missing fetch
flush  in  1  pipeline redirect; abandon current refill
memReqValid  out  1  line read request valid
memReqReady  in  1  memory accepts request
memReqAddr  out  ADDR_WIDTH  line-aligned request address (low log2(LINE_WORDS*WORD_WIDTH/8) bits zero)
memRspValid  in  1  response beat valid (no backpressure; always consumed)
memRspData  in  WORD_WIDTH  response beat, ascending word order
fillDataWE  out  1  data array write enable
fillIndex  out  INDEX_WIDTH  set index of line being filled
fillWordSel  out  log2(LINE_WORDS)  word within line
fillData  out  WORD_WIDTH  word to write
fillTagWE  out  1  tag+valid write enable
fillTag  out  ADDR_WIDTH-INDEX_WIDTH-offset  tag to write
busy  out  1  controller not IDLE; fetch must hold
refillDone  out  1  one-cycle pulse: line installed

Behaviour:
- Reset (async assert, sync release): state IDLE, beat counter 0, all outputs 0.
- States: IDLE, REQ, RESP, TAG, DONE, DRAIN.
- IDLE: missValid && !flush -> latch line-aligned missAddr, go to REQ (next cycle). missValid ignored in every other state.
- REQ: memReqValid=1, memReqAddr=latched line address, held stable until memReqReady. Handshake = valid&&ready in the same cycle -> RESP, counter=0. flush in REQ: if the handshake does not occur this cycle -> IDLE, request dropped. If the handshake occurs the same cycle -> DRAIN.
- RESP: each memRspValid cycle drives fillDataWE=1 combinationally that cycle, with fillWordSel=counter, fillData=memRspData, fillIndex from the latched address; counter increments. Beat with counter==LINE_WORDS-1 -> TAG. No beats -> hold.
- TAG: fillTagWE=1 for exactly one cycle with the latched tag/index -> DONE.
- DONE: refillDone=1 for one cycle -> IDLE. busy=0 is first seen the cycle after DONE.
- flush in RESP: go to DRAIN. A beat arriving in the flush cycle is still written. The data write is harmless because the tag is not written.
- DRAIN: consume the remaining beats with fillDataWE=0. After the last beat -> IDLE. No fillTagWE, no refillDone. A new miss is never requested while DRAIN is outstanding.
- flush in TAG: tag write still occurs (line is valid data) -> DONE, but refillDone suppressed. flush in DONE: refillDone suppressed.
- Counter is log2(LINE_WORDS) bits and returns to 0 on the last beat.
- busy=1 in every state except IDLE.
- Minimum miss latency, with ready and beats back-to-back: REQ 1 + RESP LINE_WORDS + TAG 1 + DONE 1 cycles.
- memRspValid in IDLE/REQ/TAG/DONE is a protocol error: ignored, no writes.

Optional Feature:
ICACHE_REFILL_PERF_EN
- Defined: adds outputs perfMissCount[31:0] and perfStallCycles[31:0], both reset to 0.
- perfMissCount increments on each REQ handshake.
- perfStallCycles increments every cycle busy=1.
- Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Basic refill: missAddr=0x0000_1234, memReqReady=1, 4 consecutive beats 0xA0..0xA3 -> memReqAddr=0x0000_1230; fillWordSel 0..3 carry 0xA0..0xA3; fillTagWE one cycle later; refillDone at cycle 7 after the miss; busy back to 0.
- Request backpressure: memReqReady low 5 cycles -> memReqValid and memReqAddr stable for 6 cycles; RESP entered only after the handshake.
- Gapped beats: beats arrive on cycles 1,4,5,9 after the handshake -> exactly 4 fillDataWE pulses with words 0,1,2,3; fillTagWE follows the 4th beat.
- Flush in REQ without ready -> IDLE next cycle, no memReqValid afterwards. Flush after beat 1 -> 3 remaining beats consumed with fillDataWE=0; no fillTagWE/refillDone; busy drops after the last beat. A new miss then accepted normally.
- Async reset asserted in RESP after beat 2 -> all outputs 0 immediately. After release, state IDLE, counter 0; a next miss at 0x40 gets memReqAddr=0x40.
- ICACHE_REFILL_PERF_EN: two back-to-back refills with ready=1 and contiguous beats -> perfMissCount=2, perfStallCycles=14.

Source files
------------

// File: rtl/icache_refill_controller.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_controller
// Description : I-cache miss sequencer: one line request, beat fill, tag
//               install, completion pulse; flush cancels or drains a refill.
//               Optional macro ICACHE_REFILL_PERF_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_controller #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int LINE_WORDS  = 4,
    parameter int INDEX_WIDTH = 6,
    localparam int OFFSET_WIDTH = $clog2(LINE_WORDS * WORD_WIDTH / 8),
    localparam int WSEL_WIDTH   = $clog2(LINE_WORDS),
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   missValid,
    input  logic [ADDR_WIDTH-1:0]  missAddr,
    input  logic                   flush,
    output logic                   memReqValid,
    input  logic                   memReqReady,
    output logic [ADDR_WIDTH-1:0]  memReqAddr,
    input  logic                   memRspValid,
    input  logic [WORD_WIDTH-1:0]  memRspData,
    output logic                   fillDataWE,
    output logic [INDEX_WIDTH-1:0] fillIndex,
    output logic [WSEL_WIDTH-1:0]  fillWordSel,
    output logic [WORD_WIDTH-1:0]  fillData,
    output logic                   fillTagWE,
    output logic [TAG_WIDTH-1:0]   fillTag,
    output logic                   busy,
`ifdef ICACHE_REFILL_PERF_EN
    output logic                   refillDone,
    output logic [31:0]            perfMissCount,
    output logic [31:0]            perfStallCycles
`else
    output logic                   refillDone
`endif
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_REQ   = 3'd1;
    localparam logic [2:0] c_RESP  = 3'd2;
    localparam logic [2:0] c_TAG   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;
    localparam logic [2:0] c_DRAIN = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] c_LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET_WIDTH) - ADDR_WIDTH'(1));
    localparam logic [WSEL_WIDTH-1:0] c_LAST_BEAT = WSEL_WIDTH'(LINE_WORDS - 1);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_lineAddr;
    logic [WSEL_WIDTH-1:0] r_beatCnt;
    logic                  r_suppressDone;

    logic w_reqFire;
    logic w_lastBeat;

    assign w_reqFire  = (r_state == c_REQ) && memReqReady;
    assign w_lastBeat = memRspValid && (r_beatCnt == c_LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_lineAddr     <= '0;
            r_beatCnt      <= '0;
            r_suppressDone <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (missValid && !flush) begin
                        r_lineAddr <= missAddr & c_LINE_MASK;
                        r_state    <= c_REQ;
                    end
                end
                c_REQ: begin
                    // A flush that coincides with the handshake still owes us a full line of beats.
                    if (w_reqFire) begin
                        r_beatCnt <= '0;
                        r_state   <= flush ? c_DRAIN : c_RESP;
                    end else if (flush) begin
                        r_state <= c_IDLE;
                    end
                end
                c_RESP: begin
                    if (memRspValid) begin
                        r_beatCnt <= r_beatCnt + 1'b1;
                    end
                    if (w_lastBeat) begin
                        r_state <= flush ? c_IDLE : c_TAG;
                    end else if (flush) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_TAG: begin
                    r_suppressDone <= flush;
                    r_state        <= c_DONE;
                end
                c_DONE: begin
                    r_suppressDone <= 1'b0;
                    r_state        <= c_IDLE;
                end
                c_DRAIN: begin
                    if (memRspValid) begin
                        r_beatCnt <= r_beatCnt + 1'b1;
                    end
                    if (w_lastBeat) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Payload outputs are gated by their strobes so idle outputs read as zero.
    assign busy        = (r_state != c_IDLE);
    assign memReqValid = (r_state == c_REQ);
    assign memReqAddr  = memReqValid ? r_lineAddr : '0;
    assign fillDataWE  = (r_state == c_RESP) && memRspValid;
    assign fillWordSel = fillDataWE ? r_beatCnt : '0;
    assign fillData    = fillDataWE ? memRspData : '0;
    assign fillTagWE   = (r_state == c_TAG);
    assign fillTag     = fillTagWE ? r_lineAddr[ADDR_WIDTH-1 -: TAG_WIDTH] : '0;
    assign fillIndex   = (fillDataWE || fillTagWE) ? r_lineAddr[OFFSET_WIDTH +: INDEX_WIDTH] : '0;
    assign refillDone  = (r_state == c_DONE) && !flush && !r_suppressDone;

`ifdef ICACHE_REFILL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfMissCount   <= '0;
            perfStallCycles <= '0;
        end else begin
            if (w_reqFire && (perfMissCount != 32'hFFFF_FFFF)) begin
                perfMissCount <= perfMissCount + 32'd1;
            end
            if (busy && (perfStallCycles != 32'hFFFF_FFFF)) begin
                perfStallCycles <= perfStallCycles + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
